// File: rtl/tb_lights_pkg.sv
// Shared types and constants for the Thunderbird tail-light sequencer controller.
// The arbitration helper is shared by every state that re-arbitrates.
package tb_lights_pkg;

   typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZ, FLUSH} state_e;

   localparam int unsigned TURN_STEPS = 4;
   localparam int unsigned HAZ_STEPS  = 2;

   // Hazard wins over both turns; left wins over right.
   function automatic state_e arbitrate(input logic hz_req, input logic l_req, input logic r_req);
      state_e result;
      result = IDLE;
      if (hz_req) begin
         result = HAZ;
      end else if (l_req) begin
         result = LEFT;
      end else if (r_req) begin
         result = RIGHT;
      end
      return result;
   endfunction

endpackage

// File: rtl/tb_light_sequencer_if.sv
// Driver-request inputs and datapath-control outputs of the tail-light sequencer.
interface tb_light_sequencer_if;

   logic turn_l;
   logic turn_r;
   logic hazard;
   logic step;
   logic L;
   logic R;
   logic H;
   logic busy;

   modport master (
      output turn_l, turn_r, hazard,
      input  step, L, R, H, busy
   );

   modport slave (
      input  turn_l, turn_r, hazard,
      output step, L, R, H, busy
   );

endinterface

// File: rtl/tb_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module tb_sync2 (
   input  logic clk,
   input  logic clear,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/tb_light_sequencer.sv
// Tail-light sequencer controller: synchronizes driver switches, generates the step strobe,
// and holds L/R/H stable across whole sweeps.
module tb_light_sequencer
   import tb_lights_pkg::*;
#(
   parameter int unsigned DIV = 4,
   parameter int unsigned CW  = 24
) (
   input  logic                 clk,
   input  logic                 clear,
   tb_light_sequencer_if.slave  lights
);

   logic sl;
   logic sr;
   logic sh;
   logic hz_req;
   logic l_req;
   logic r_req;

   tb_sync2 u_sync_l (.clk(clk), .clear(clear), .d(lights.turn_l), .q(sl));
   tb_sync2 u_sync_r (.clk(clk), .clear(clear), .d(lights.turn_r), .q(sr));
   tb_sync2 u_sync_h (.clk(clk), .clear(clear), .d(lights.hazard), .q(sh));

   // Both turn stalks at once are treated as a hazard request.
   assign hz_req = sh | (sl & sr);
   assign l_req  = sl & ~hz_req;
   assign r_req  = sr & ~hz_req;

   logic [CW-1:0] presc_q;
   logic          step_q;

   // step_q is set one count early so it is high exactly while presc_q == DIV-1.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         presc_q <= '0;
         step_q  <= 1'b0;
      end else begin
         presc_q <= (presc_q == CW'(DIV - 1)) ? '0 : presc_q + CW'(1);
         step_q  <= (presc_q == CW'(DIV - 2));
      end
   end

   state_e     state_q;
   state_e     state_d;
   logic [1:0] phase_q;
   logic [1:0] phase_d;
   logic       l_q;
   logic       r_q;
   logic       h_q;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      unique case (state_q)
         IDLE: begin
            state_d = arbitrate(hz_req, l_req, r_req);
            phase_d = '0;
         end
         LEFT, RIGHT: begin
            if (hz_req) begin
               state_d = FLUSH;
               phase_d = '0;
            end else if (phase_q == 2'(TURN_STEPS - 1)) begin
               state_d = arbitrate(hz_req, l_req, r_req);
               phase_d = '0;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         HAZ: begin
            if (phase_q == 2'(HAZ_STEPS - 1)) begin
               state_d = arbitrate(hz_req, l_req, r_req);
               phase_d = '0;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         FLUSH: begin
            state_d = arbitrate(hz_req, l_req, r_req);
            phase_d = '0;
         end
         default: begin
            state_d = IDLE;
            phase_d = '0;
         end
      endcase
   end

   // Mode outputs are decoded from the next state so they switch on the same step edge.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         phase_q <= '0;
         l_q     <= 1'b0;
         r_q     <= 1'b0;
         h_q     <= 1'b0;
      end else if (step_q) begin
         state_q <= state_d;
         phase_q <= phase_d;
         l_q     <= (state_d == LEFT);
         r_q     <= (state_d == RIGHT);
         h_q     <= (state_d == HAZ);
      end
   end

   assign lights.step = step_q;
   assign lights.L    = l_q;
   assign lights.R    = r_q;
   assign lights.H    = h_q;
   assign lights.busy = (state_q != IDLE);

endmodule

// File: tb/tb_tb_light_sequencer.sv
// Directed bench for tb_light_sequencer with DIV=4; outputs sampled 1 time unit after posedge.
module tb_tb_light_sequencer;

   localparam int unsigned DIV = 4;
   localparam int unsigned CW  = 24;

   logic clk = 1'b0;
   logic clear;
   int   checks = 0;
   int   errors = 0;

   tb_light_sequencer_if lights ();

   tb_light_sequencer #(.DIV(DIV), .CW(CW)) dut (
      .clk   (clk),
      .clear (clear),
      .lights(lights)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advances past the next step cycle so the caller sees the freshly updated outputs.
   task automatic next_update(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2 * DIV + 2; i++) begin
         @(posedge clk);
         #1;
         if (lights.step === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      assert (ok) else begin
         errors++;
         $error("FAIL %s: observed no step pulse, expected one within %0d cycles", tag, 2 * DIV + 2);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_lrhb(input string tag, input logic l, input logic r, input logic h,
                             input logic b);
      check({tag, "_L"}, lights.L, l);
      check({tag, "_R"}, lights.R, r);
      check({tag, "_H"}, lights.H, h);
      check({tag, "_busy"}, lights.busy, b);
   endtask

   initial begin
      bit found;

      // Reset with every request asserted.
      clear         = 1'b0;
      lights.turn_l = 1'b1;
      lights.turn_r = 1'b1;
      lights.hazard = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_step", lights.step, 1'b0);
      check_lrhb("rst", 1'b0, 1'b0, 1'b0, 1'b0);

      lights.turn_l = 1'b0;
      lights.turn_r = 1'b0;
      lights.hazard = 1'b0;
      @(posedge clk);
      #1;
      clear = 1'b1;
      for (int i = 1; i <= 3 * DIV; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("step_period_%0d", i), lights.step, (i % DIV) == DIV - 1);
      end
      check_lrhb("idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // Left sweep: short pulse still yields a full 4-step sweep, then idle.
      lights.turn_l = 1'b1;
      next_update("left_u1");
      check_lrhb("left_s1", 1'b1, 1'b0, 1'b0, 1'b1);
      next_update("left_u2");
      check_lrhb("left_s2", 1'b1, 1'b0, 1'b0, 1'b1);
      lights.turn_l = 1'b0;
      next_update("left_u3");
      check_lrhb("left_s3", 1'b1, 1'b0, 1'b0, 1'b1);
      next_update("left_u4");
      check_lrhb("left_s4", 1'b1, 1'b0, 1'b0, 1'b1);
      next_update("left_u5");
      check_lrhb("left_end", 1'b0, 1'b0, 1'b0, 1'b0);

      // Both turns together act as hazard.
      lights.turn_l = 1'b1;
      lights.turn_r = 1'b1;
      next_update("both_u1");
      check_lrhb("both_s1", 1'b0, 1'b0, 1'b1, 1'b1);
      next_update("both_u2");
      check_lrhb("both_s2", 1'b0, 1'b0, 1'b1, 1'b1);
      next_update("both_u3");
      check_lrhb("both_s3", 1'b0, 1'b0, 1'b1, 1'b1);
      next_update("both_u4");
      check_lrhb("both_s4", 1'b0, 1'b0, 1'b1, 1'b1);
      lights.turn_l = 1'b0;
      lights.turn_r = 1'b0;
      next_update("both_u5");
      check_lrhb("both_end", 1'b0, 1'b0, 1'b0, 1'b0);

      // Hazard preempts a right sweep at phase 1 via one FLUSH step.
      lights.turn_r = 1'b1;
      next_update("pre_u1");
      check_lrhb("pre_r0", 1'b0, 1'b1, 1'b0, 1'b1);
      next_update("pre_u2");
      check_lrhb("pre_r1", 1'b0, 1'b1, 1'b0, 1'b1);
      lights.turn_r = 1'b0;
      lights.hazard = 1'b1;
      next_update("pre_u3");
      check_lrhb("pre_flush", 1'b0, 1'b0, 1'b0, 1'b1);
      next_update("pre_u4");
      check_lrhb("pre_haz0", 1'b0, 1'b0, 1'b1, 1'b1);
      lights.hazard = 1'b0;
      next_update("pre_u5");
      check_lrhb("pre_haz1", 1'b0, 1'b0, 1'b1, 1'b1);
      next_update("pre_u6");
      check_lrhb("pre_end", 1'b0, 1'b0, 1'b0, 1'b0);

      // Right to left with no idle step between sweeps.
      lights.turn_r = 1'b1;
      next_update("b2b_u1");
      check_lrhb("b2b_r0", 1'b0, 1'b1, 1'b0, 1'b1);
      next_update("b2b_u2");
      check_lrhb("b2b_r1", 1'b0, 1'b1, 1'b0, 1'b1);
      next_update("b2b_u3");
      check_lrhb("b2b_r2", 1'b0, 1'b1, 1'b0, 1'b1);
      lights.turn_r = 1'b0;
      lights.turn_l = 1'b1;
      next_update("b2b_u4");
      check_lrhb("b2b_r3", 1'b0, 1'b1, 1'b0, 1'b1);
      next_update("b2b_u5");
      check_lrhb("b2b_l0", 1'b1, 1'b0, 1'b0, 1'b1);
      lights.turn_l = 1'b0;
      repeat (3) next_update("b2b_lrest");
      check_lrhb("b2b_l3", 1'b1, 1'b0, 1'b0, 1'b1);
      next_update("b2b_u9");
      check_lrhb("b2b_end", 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset while in HAZ, then restart with hazard still high.
      lights.hazard = 1'b1;
      next_update("rst_u1");
      check_lrhb("rst_haz", 1'b0, 1'b0, 1'b1, 1'b1);
      #2;
      clear = 1'b0;
      #1;
      check_lrhb("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      clear = 1'b1;
      found = 1'b0;
      for (int i = 1; i <= 2 + DIV + 1; i++) begin
         @(posedge clk);
         #1;
         if (i < DIV) begin
            check($sformatf("rst_h_low_%0d", i), lights.H, 1'b0);
         end
         if (lights.H === 1'b1) begin
            found = 1'b1;
         end
      end
      check("rst_h_relatch", found, 1'b1);
      check("rst_busy_after", lights.busy, 1'b1);
      lights.hazard = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
